config_frame_loader: RTL and testbench
======================================

Name: config_frame_loader

Overview:
- Upstream feeder of the per-column frame-select stage.
- Consumes a 32-bit bitstream word stream (valid/ready), detects sync/desync words and decodes frame-address words.
- Assembles one frame of configuration data, then issues a single-cycle column/frame strobe.
- Outputs drive the shared FrameData bus and the FrameSelect, FrameStrobe and FrameStrobe_I inputs of every column's frame-select instance.

Parameters:
- MaxFramesPerCol, 20, number of frames per column; width of the row strobe vector.
- FrameSelectWidth, 5, width of the column-select field.
- NumColumns, 11, number of valid columns; column indices >= NumColumns are illegal.
- NumberOfRows, 16, number of 32-bit words per frame.
- SyncWord, 32'hFAB0_FAB1, enters configuration mode.
- DesyncWord, 32'hFAB0_FAB0, leaves configuration mode.

Ports:
- CLK  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- word_data  in  32  bitstream word.
- word_valid  in  1  word_data is valid.
- word_ready  out  1  a word is accepted on any cycle where word_valid && word_ready.
- FrameData  out  32*NumberOfRows  assembled frame; word 0 occupies the top 32 bits.
- FrameSelect  out  FrameSelectWidth  target column.
- FrameStrobe  out  1  one-cycle write strobe.
- FrameStrobe_I  out  MaxFramesPerCol  one-hot frame index, nonzero only while FrameStrobe is high.
- config_active  out  1  high between sync and desync.
- cfg_error  out  1  sticky illegal-address flag (CRC failure also sets it when CONFIG_CRC_EN is defined).
- frames_written  out  16  saturating count of strobes issued.

Behaviour:
- Reset (async, resetn=0): state=IDLE; all outputs 0 except word_ready=1. FrameData is cleared.
- States: IDLE, ADDR, DATA, STROBE.
- IDLE:
  - Accepts and discards every word.
  - SyncWord -> ADDR; config_active=1 from the next cycle.
- ADDR:
  - DesyncWord -> IDLE; config_active=0 next cycle.
  - SyncWord is ignored; stay in ADDR.
  - Any other word is an address: col=word[31:27], frame=word[4:0]; both are latched; word counter=0 -> DATA.
  - Illegal address: col >= NumColumns or frame >= MaxFramesPerCol. The bad flag is latched and cfg_error is set the next cycle (sticky until reset).
- DATA:
  - Each accepted word shifts into FrameData from the LSB end, so the first word ends in the top slot. The counter increments.
  - The word accepted with counter == NumberOfRows-1 ends the frame. If bad=0 -> STROBE; if bad=1 -> ADDR with no strobe (data discarded, FrameData still updated).
  - Sync/desync values are treated as data while in DATA.
- STROBE (exactly one cycle):
  - word_ready=0; FrameStrobe=1; FrameSelect=col; FrameStrobe_I=1<<frame.
  - frames_written increments and saturates at 16'hFFFF.
  - Next state: ADDR.
- FrameSelect holds its value after the strobe. FrameData holds until the next data word.
- Latency: the strobe is asserted the cycle after the last data word handshake.
- word_ready is 1 in every state except STROBE. word_valid gaps stall the FSM without side effects.
- resetn asserted mid-frame aborts immediately. After release, the block requires a new SyncWord.

Optional Feature:
- Macro: CONFIG_CRC_EN.
- Defined:
  - An extra CHECK state follows DATA.
  - A running XOR of the address word and all data words is compared against one further check word.
  - Match with bad=0 -> STROBE. Mismatch -> cfg_error set, no strobe, -> ADDR.
  - The check word is accepted even when bad=1.
- Undefined: no check word; DATA goes directly to STROBE/ADDR as above.

Decomposition:
- Shared config package holds:
  - state enum;
  - SyncWord/DesyncWord constants;
  - address field bit positions (col [31:27], frame [4:0]);
  - MaxFramesPerCol and FrameSelectWidth defaults.
- One natural sub-module: config_frame_shiftreg. It holds the NumberOfRows x 32 shift register, the word counter and the last-word flag.

Test Plan:
- Sync, then address 32'h1000_0003 (col 2, frame 3), then 16 data words 0..15 -> one cycle with FrameStrobe=1, FrameSelect=2, FrameStrobe_I=20'h00008, FrameData top word=0 and bottom word=15; frames_written=1.
- Words before sync, including an address-like word -> no strobe; config_active=0.
- Address col 12 (illegal with NumColumns=11) plus 16 data words -> cfg_error=1, no strobe. A following valid frame still strobes while cfg_error stays 1.
- word_valid toggling every other cycle during DATA -> strobe one cycle after the 16th handshake. word_ready=0 only in the strobe cycle.
- resetn pulsed low after 8 data words -> outputs clear immediately. A fresh sync plus a full frame strobes normally.
- CONFIG_CRC_EN: correct XOR check word -> strobe. Check word with one bit flipped -> no strobe, cfg_error=1.

Source files
------------

// File: rtl/config_frame_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : config_frame_loader_pkg
// Description : Shared definitions for the configuration frame loader:
//               FSM state encoding, sync/desync bitstream words, address
//               field positions and frame-select geometry defaults.
// Options     : CONFIG_CRC_EN (state ST_CHECK is only reachable when defined)
// Revision    : 1.0 - initial release
// ============================================================================
package config_frame_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_STROBE = 3'd3,
        ST_CHECK  = 3'd4
    } state_t;

    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

    // Address word layout: column in the top five bits, frame in the bottom five.
    localparam int COL_MSB   = 31;
    localparam int COL_LSB   = 27;
    localparam int FRAME_MSB = 4;
    localparam int FRAME_LSB = 0;
    localparam int COL_W     = COL_MSB - COL_LSB + 1;
    localparam int FRAME_W   = FRAME_MSB - FRAME_LSB + 1;

    localparam int MAX_FRAMES_PER_COL_DEF = 20;
    localparam int FRAME_SELECT_WIDTH_DEF = 5;

    // An address is usable only when both fields index existing hardware.
    function automatic logic addr_is_legal(
        input logic [COL_W-1:0]   col,
        input logic [FRAME_W-1:0] frame,
        input int                 num_cols,
        input int                 max_frames
    );
        return (int'(col) < num_cols) && (int'(frame) < max_frames);
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_frame_shiftreg.sv
`default_nettype none
// ============================================================================
// Module      : config_frame_shiftreg
// Description : Frame assembly buffer. Words shift in from the LSB end so the
//               first word of a frame ends up in the top 32-bit slot. Tracks
//               the word position and flags the last word of the frame.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               clr_cnt_i         - restart word counter (new address)
//               shift_i           - accept word_i into the buffer
//               word_i            - incoming data word
//               frame_data_o      - assembled frame (NumberOfRows x 32)
//               last_word_o       - current word position is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module config_frame_shiftreg #(
    parameter int NumberOfRows = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_cnt_i,
    input  logic                         shift_i,
    input  logic [31:0]                  word_i,
    output logic [32*NumberOfRows-1:0]   frame_data_o,
    output logic                         last_word_o
);

    localparam int CNT_W = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

    logic [CNT_W-1:0]          cnt_q;
    logic [32*NumberOfRows-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_cnt_i) begin
            cnt_q <= '0;
        end else if (shift_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    generate
        if (NumberOfRows == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (shift_i) begin
                    data_q <= word_i;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (shift_i) begin
                    data_q <= {data_q[32*NumberOfRows-33:0], word_i};
                end
            end
        end
    endgenerate

    assign frame_data_o = data_q;
    assign last_word_o  = (cnt_q == CNT_W'(NumberOfRows - 1));

endmodule
`default_nettype wire

// File: rtl/config_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : config_frame_loader
// Description : Bitstream front end for the per-column frame-select stage.
//               Waits for the sync word, decodes frame-address words,
//               collects one frame of data and issues a single-cycle
//               column/frame strobe. Desync returns to idle.
// Ports       : CLK, resetn        - clock, asynchronous active-low reset
//               word_data/valid/ready - bitstream word handshake
//               FrameData          - assembled frame, word 0 in the top slot
//               FrameSelect        - target column (held after the strobe)
//               FrameStrobe        - one-cycle write strobe
//               FrameStrobe_I      - one-hot frame index during the strobe
//               config_active      - between sync and desync
//               cfg_error          - sticky error flag
//               frames_written     - saturating strobe counter
// Options     : CONFIG_CRC_EN - adds a check word after each frame holding
//               the XOR of the address word and all data words.
// Revision    : 1.0 - initial release
// ============================================================================
module config_frame_loader
    import config_frame_loader_pkg::*;
#(
    parameter int MaxFramesPerCol  = MAX_FRAMES_PER_COL_DEF,
    parameter int FrameSelectWidth = FRAME_SELECT_WIDTH_DEF,
    parameter int NumColumns       = 11,
    parameter int NumberOfRows     = 16
) (
    input  logic                         CLK,
    input  logic                         resetn,
    input  logic [31:0]                  word_data,
    input  logic                         word_valid,
    output logic                         word_ready,
    output logic [32*NumberOfRows-1:0]   FrameData,
    output logic [FrameSelectWidth-1:0]  FrameSelect,
    output logic                         FrameStrobe,
    output logic [MaxFramesPerCol-1:0]   FrameStrobe_I,
    output logic                         config_active,
    output logic                         cfg_error,
    output logic [15:0]                  frames_written
);

    state_t                      state_q, state_d;
    logic [COL_W-1:0]            col_q, col_d;
    logic [FRAME_W-1:0]          frame_q, frame_d;
    logic                        bad_q, bad_d;
    logic                        err_q, err_d;
    logic [FrameSelectWidth-1:0] sel_q, sel_d;
    logic [15:0]                 nwr_q, nwr_d;
`ifdef CONFIG_CRC_EN
    logic [31:0]                 crc_q, crc_d;
`endif

    logic               accept;
    logic               shift;
    logic               clr_cnt;
    logic               last_word;
    logic [COL_W-1:0]   w_col;
    logic [FRAME_W-1:0] w_frame;
    logic               w_legal;

    assign accept  = word_valid && word_ready;
    assign w_col   = word_data[COL_MSB:COL_LSB];
    assign w_frame = word_data[FRAME_MSB:FRAME_LSB];
    assign w_legal = addr_is_legal(w_col, w_frame, NumColumns, MaxFramesPerCol);

    config_frame_shiftreg #(
        .NumberOfRows (NumberOfRows)
    ) u_shiftreg (
        .clk          (CLK),
        .rst_n        (resetn),
        .clr_cnt_i    (clr_cnt),
        .shift_i      (shift),
        .word_i       (word_data),
        .frame_data_o (FrameData),
        .last_word_o  (last_word)
    );

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            frame_q <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            nwr_q   <= '0;
`ifdef CONFIG_CRC_EN
            crc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            frame_q <= frame_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            nwr_q   <= nwr_d;
`ifdef CONFIG_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        frame_d = frame_q;
        bad_d   = bad_q;
        err_d   = err_q;
        sel_d   = sel_q;
        nwr_d   = nwr_q;
        shift   = 1'b0;
        clr_cnt = 1'b0;
`ifdef CONFIG_CRC_EN
        crc_d   = crc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept && (word_data == SYNC_WORD)) begin
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (accept) begin
                    if (word_data == DESYNC_WORD) begin
                        state_d = ST_IDLE;
                    end else if (word_data != SYNC_WORD) begin
                        col_d   = w_col;
                        frame_d = w_frame;
                        bad_d   = !w_legal;
                        if (!w_legal) begin
                            err_d = 1'b1;
                        end
                        clr_cnt = 1'b1;
`ifdef CONFIG_CRC_EN
                        crc_d   = word_data;
`endif
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                // Sync/desync values are plain payload here.
                if (accept) begin
                    shift = 1'b1;
`ifdef CONFIG_CRC_EN
                    crc_d = crc_q ^ word_data;
                    if (last_word) begin
                        state_d = ST_CHECK;
                    end
`else
                    if (last_word) begin
                        if (bad_q) begin
                            state_d = ST_ADDR;
                        end else begin
                            state_d = ST_STROBE;
                            sel_d   = FrameSelectWidth'(col_q);
                        end
                    end
`endif
                end
            end

`ifdef CONFIG_CRC_EN
            ST_CHECK: begin
                // The check word is consumed even for a bad address so the
                // stream stays aligned to the next address word.
                if (accept) begin
                    if ((word_data == crc_q) && !bad_q) begin
                        state_d = ST_STROBE;
                        sel_d   = FrameSelectWidth'(col_q);
                    end else begin
                        if (word_data != crc_q) begin
                            err_d = 1'b1;
                        end
                        state_d = ST_ADDR;
                    end
                end
            end
`endif

            ST_STROBE: begin
                if (nwr_q != 16'hFFFF) begin
                    nwr_d = nwr_q + 16'd1;
                end
                state_d = ST_ADDR;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign word_ready     = (state_q != ST_STROBE);
    assign FrameStrobe    = (state_q == ST_STROBE);
    assign FrameStrobe_I  = FrameStrobe ? (MaxFramesPerCol'(1) << frame_q) : '0;
    assign FrameSelect    = sel_q;
    assign config_active  = (state_q != ST_IDLE);
    assign cfg_error      = err_q;
    assign frames_written = nwr_q;

endmodule
`default_nettype wire

// File: tb/tb_config_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_config_frame_loader
// Description : Directed self-checking bench for config_frame_loader.
//               Build with +define+CONFIG_CRC_EN to exercise the check word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_frame_loader;

    localparam int ROWS = 16;
    localparam int FDW  = 32 * ROWS;
    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    logic            CLK;
    logic            resetn;
    logic [31:0]     word_data;
    logic            word_valid;
    logic            word_ready;
    logic [FDW-1:0]  FrameData;
    logic [4:0]      FrameSelect;
    logic            FrameStrobe;
    logic [19:0]     FrameStrobe_I;
    logic            config_active;
    logic            cfg_error;
    logic [15:0]     frames_written;

    int checks;
    int errors;
    int strobe_cnt;
    int ready_bad;
    int s0;

    config_frame_loader #(
        .MaxFramesPerCol  (20),
        .FrameSelectWidth (5),
        .NumColumns       (11),
        .NumberOfRows     (ROWS)
    ) dut (
        .CLK            (CLK),
        .resetn         (resetn),
        .word_data      (word_data),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .FrameData      (FrameData),
        .FrameSelect    (FrameSelect),
        .FrameStrobe    (FrameStrobe),
        .FrameStrobe_I  (FrameStrobe_I),
        .config_active  (config_active),
        .cfg_error      (cfg_error),
        .frames_written (frames_written)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Counted at the active edge so values belong to the cycle just ending.
    always @(posedge CLK) begin
        if (FrameStrobe === 1'b1) strobe_cnt++;
        if (word_ready !== !FrameStrobe) ready_bad++;
        if (FrameStrobe !== 1'b1 && FrameStrobe_I !== 20'h0) ready_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present one word at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [31:0] w);
        int n;
        word_data  = w;
        word_valid = 1'b1;
        n = 0;
        while (word_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (word_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word_ready=%b required 1", word_ready);
        end
        @(negedge CLK);
        word_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] addr, input logic [31:0] base,
                              input bit gap, input logic [31:0] flip);
        logic [31:0] x;
        logic [31:0] w;
        send(addr);
        x = addr;
        for (int i = 0; i < ROWS; i++) begin
            w = base + 32'(i);
            send(w);
            x = x ^ w;
            if (gap && i < ROWS - 1) @(negedge CLK);
        end
`ifdef CONFIG_CRC_EN
        send(x ^ flip);
`else
        x = x ^ flip;
`endif
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", word_ready); end
        checks++; if (FrameStrobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", FrameStrobe); end
        checks++; if (FrameStrobe_I !== 20'h0) begin errors++; $display("FAIL reset_strobe_i: got %h want 0", FrameStrobe_I); end
        checks++; if (config_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", config_active); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", cfg_error); end
        checks++; if (frames_written !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", frames_written); end
        checks++; if (FrameData !== '0) begin errors++; $display("FAIL reset_framedata: got nonzero want 0"); end
        checks++; if (FrameSelect !== 5'd0) begin errors++; $display("FAIL reset_select: got %0d want 0", FrameSelect); end
        resetn = 1'b1;
        @(negedge CLK);
        checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", word_ready); end
    endtask

    task automatic test_pre_sync();
        s0 = strobe_cnt;
        send_frame(32'h1000_0003, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL presync_strobe: got %0d strobes want 0", strobe_cnt - s0); end
        checks++; if (config_active !== 1'b0) begin errors++; $display("FAIL presync_active: got %b want 0", config_active); end
    endtask

    task automatic test_basic_frame();
        send(SYNC);
        checks++; if (config_active !== 1'b1) begin errors++; $display("FAIL sync_active: got %b want 1", config_active); end
        send_frame(32'h1000_0003, 32'h0, 1'b0, 32'h0);
        checks++; if (FrameStrobe !== 1'b1) begin errors++; $display("FAIL basic_strobe: got %b want 1", FrameStrobe); end
        checks++; if (FrameSelect !== 5'd2) begin errors++; $display("FAIL basic_select: got %0d want 2", FrameSelect); end
        checks++; if (FrameStrobe_I !== 20'h00008) begin errors++; $display("FAIL basic_strobe_i: got %h want 00008", FrameStrobe_I); end
        checks++; if (FrameData[FDW-1 -: 32] !== 32'd0) begin errors++; $display("FAIL basic_top_word: got %h want 0", FrameData[FDW-1 -: 32]); end
        checks++; if (FrameData[31:0] !== 32'd15) begin errors++; $display("FAIL basic_bottom_word: got %h want f", FrameData[31:0]); end
        checks++; if (FrameData[FDW-33 -: 32] !== 32'd1) begin errors++; $display("FAIL basic_word1: got %h want 1", FrameData[FDW-33 -: 32]); end
        checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low: got %b want 0", word_ready); end
        @(negedge CLK);
        checks++; if (FrameStrobe !== 1'b0) begin errors++; $display("FAIL basic_strobe_single: got %b want 0", FrameStrobe); end
        checks++; if (frames_written !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", frames_written); end
        checks++; if (FrameSelect !== 5'd2) begin errors++; $display("FAIL basic_select_hold: got %0d want 2", FrameSelect); end
        checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b want 1", word_ready); end
    endtask

    task automatic test_illegal_addr();
        s0 = strobe_cnt;
        send(32'h6000_0001);   // column 12
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL illegal_col_error: got %b want 1", cfg_error); end
        s0 = strobe_cnt;
        for (int i = 0; i < ROWS; i++) send(32'h100 + 32'(i));
`ifdef CONFIG_CRC_EN
        begin
            logic [31:0] x;
            x = 32'h6000_0001;
            for (int i = 0; i < ROWS; i++) x = x ^ (32'h100 + 32'(i));
            send(x);
        end
`endif
        @(negedge CLK);
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL illegal_col_strobe: got %0d strobes want 0", strobe_cnt - s0); end
        checks++; if (FrameData[31:0] !== 32'h10F) begin errors++; $display("FAIL illegal_data_updated: got %h want 10f", FrameData[31:0]); end
        checks++; if (FrameSelect !== 5'd2) begin errors++; $display("FAIL illegal_select_hold: got %0d want 2", FrameSelect); end
        // Frame 20 is out of range on a legal column.
        s0 = strobe_cnt;
        send_frame(32'h0000_0014, 32'h200, 1'b0, 32'h0);
        @(negedge CLK);
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL illegal_frame_strobe: got %0d strobes want 0", strobe_cnt - s0); end
        // Highest legal column and frame.
        send_frame(32'h5000_0013, 32'hA0, 1'b0, 32'h0);
        checks++; if (FrameStrobe !== 1'b1) begin errors++; $display("FAIL edge_strobe: got %b want 1", FrameStrobe); end
        checks++; if (FrameSelect !== 5'd10) begin errors++; $display("FAIL edge_select: got %0d want 10", FrameSelect); end
        checks++; if (FrameStrobe_I !== 20'h80000) begin errors++; $display("FAIL edge_strobe_i: got %h want 80000", FrameStrobe_I); end
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL error_sticky: got %b want 1", cfg_error); end
        @(negedge CLK);
        checks++; if (frames_written !== 16'd2) begin errors++; $display("FAIL edge_count: got %0d want 2", frames_written); end
    endtask

    task automatic test_valid_gaps();
        send_frame(32'h0800_0000, 32'h55, 1'b1, 32'h0);
        checks++; if (FrameStrobe !== 1'b1) begin errors++; $display("FAIL gaps_strobe: got %b want 1", FrameStrobe); end
        checks++; if (FrameSelect !== 5'd1) begin errors++; $display("FAIL gaps_select: got %0d want 1", FrameSelect); end
        checks++; if (FrameStrobe_I !== 20'h00001) begin errors++; $display("FAIL gaps_strobe_i: got %h want 00001", FrameStrobe_I); end
        checks++; if (FrameData[FDW-1 -: 32] !== 32'h55) begin errors++; $display("FAIL gaps_top_word: got %h want 55", FrameData[FDW-1 -: 32]); end
        @(negedge CLK);
        checks++; if (ready_bad !== 0) begin errors++; $display("FAIL ready_only_in_strobe: got %0d bad cycles want 0", ready_bad); end
    endtask

    task automatic test_desync();
        send(SYNC);   // ignored in ADDR
        checks++; if (config_active !== 1'b1) begin errors++; $display("FAIL resync_active: got %b want 1", config_active); end
        send(DESYNC);
        checks++; if (config_active !== 1'b0) begin errors++; $display("FAIL desync_active: got %b want 0", config_active); end
        s0 = strobe_cnt;
        send_frame(32'h1000_0003, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL desync_strobe: got %0d strobes want 0", strobe_cnt - s0); end
    endtask

    task automatic test_reset_midframe();
        send(SYNC);
        send(32'h1800_0002);
        for (int i = 0; i < 8; i++) send(32'h300 + 32'(i));
        resetn = 1'b0;
        #1;
        checks++; if (FrameData !== '0) begin errors++; $display("FAIL midrst_framedata: got nonzero want 0"); end
        checks++; if (config_active !== 1'b0) begin errors++; $display("FAIL midrst_active: got %b want 0", config_active); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL midrst_error: got %b want 0", cfg_error); end
        checks++; if (frames_written !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", frames_written); end
        checks++; if (FrameSelect !== 5'd0) begin errors++; $display("FAIL midrst_select: got %0d want 0", FrameSelect); end
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        s0 = strobe_cnt;
        send_frame(32'h1800_0002, 32'h300, 1'b0, 32'h0);
        @(negedge CLK);
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL midrst_needs_sync: got %0d strobes want 0", strobe_cnt - s0); end
        send(SYNC);
        send_frame(32'h1800_0002, 32'h300, 1'b0, 32'h0);
        checks++; if (FrameStrobe !== 1'b1) begin errors++; $display("FAIL midrst_strobe: got %b want 1", FrameStrobe); end
        checks++; if (FrameStrobe_I !== 20'h00004) begin errors++; $display("FAIL midrst_strobe_i: got %h want 00004", FrameStrobe_I); end
        checks++; if (FrameSelect !== 5'd3) begin errors++; $display("FAIL midrst_select_new: got %0d want 3", FrameSelect); end
        @(negedge CLK);
        checks++; if (frames_written !== 16'd1) begin errors++; $display("FAIL midrst_count_new: got %0d want 1", frames_written); end
    endtask

`ifdef CONFIG_CRC_EN
    task automatic test_crc();
        send_frame(32'h2000_0005, 32'h1234_0000, 1'b0, 32'h0);
        checks++; if (FrameStrobe !== 1'b1) begin errors++; $display("FAIL crc_good_strobe: got %b want 1", FrameStrobe); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL crc_good_error: got %b want 0", cfg_error); end
        @(negedge CLK);
        s0 = strobe_cnt;
        send_frame(32'h2000_0005, 32'h1234_0000, 1'b0, 32'h0000_0100);
        @(negedge CLK);
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL crc_bad_strobe: got %0d strobes want 0", strobe_cnt - s0); end
        checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL crc_bad_error: got %b want 1", cfg_error); end
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        strobe_cnt = 0;
        ready_bad  = 0;
        resetn     = 1'b0;
        word_valid = 1'b0;
        word_data  = 32'h0;
        test_reset();
        test_pre_sync();
        test_basic_frame();
        test_illegal_addr();
        test_valid_gaps();
        test_desync();
        test_reset_midframe();
`ifdef CONFIG_CRC_EN
        test_crc();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
